// File: rtl/imem_loader.sv
// imem_loader: 8N1 UART program loader for the CPU instruction memory.
// While load is high, received bytes are packed big-endian into 32-bit
// words and written at sequential word-aligned addresses starting at 0.
// cpu_hold mirrors the registered load level so the CPU stays in reset.
module imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic [ADDR_W-2:0] word_count,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int COUNT_W  = ADDR_W - 2;

    localparam logic [CNT_W-1:0]   HALF_CNT  = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = {{COUNT_W{1'b1}}, 2'b00};
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t state, state_next;

    logic               rx_meta, rx_sync;
    logic               load_q, load_d;
    logic               load_rise, load_fall;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         rx_byte;
    logic [23:0]        word_shift;
    logic [1:0]         byte_idx;
    logic [COUNT_W-1:0] count_q;
    logic               full;

    // Decode strobes produced by the receiver FSM.
    logic cnt_clear;
    logic shift_en;
    logic byte_valid;
    logic stop_bad;

    assign load_rise  = load_q & ~load_d;
    assign load_fall  = ~load_q & load_d;
    assign cpu_hold   = load_q;
    assign word_count = {1'b0, count_q};

    // Two-flop rx synchronizer (idle-high) and registered load level with edge history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            load_q  <= 1'b0;
            load_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking so rx_sync takes the previous rx_meta, giving two real flop stages.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            load_q  <= load;
            load_d  <= load_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receiver next-state and sample-point decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        byte_valid = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_sync) state_next = S_START;
            end
            S_START: begin
                // Mid-point of the start bit; a high level here was only a glitch.
                if (cnt == HALF_CNT) begin
                    cnt_clear  = 1'b1;
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                // A broken frame may leave the line low; wait for idle before hunting again.
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (!load_q) state_next = S_IDLE;
    end

    // Bit-period counter, data-bit index and LSB-first byte shifter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            if (cnt_clear) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) rx_byte <= {rx_sync, rx_byte[7:1]};
        end
    end

    // Word assembly, write strobe, address/count advance and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            word_shift <= 24'h0;
            byte_idx   <= 2'd0;
            count_q    <= '0;
            full       <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            if (byte_valid) begin
                word_shift <= {word_shift[15:0], rx_byte};
                byte_idx   <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {word_shift, rx_byte};
                    end
                end
            end

            if (stop_bad) begin
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
            end

            // Advance one cycle after the strobe so addr/data stay valid during it.
            // The last address is sticky through a separate flag, since imem_addr never wraps.
            if (imem_we) begin
                if (imem_addr == ADDR_LAST) begin
                    full <= 1'b1;
                end else begin
                    imem_addr <= imem_addr + ADDR_W'(4);
                end
                if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
            end

            if (load_fall) byte_idx <= 2'd0;

            if (load_rise) begin
                imem_addr <= '0;
                count_q   <= '0;
                byte_idx  <= 2'd0;
                full      <= 1'b0;
                frame_err <= 1'b0;
                overflow  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized UART stimulus for imem_loader, checked against
// a word-level model (queue of received bytes, expected write list, counts).
module tb_imem_loader;

    localparam int CPB   = 4;
    localparam int AW    = 9;
    localparam int WORDS = 1 << (AW - 2);

    logic          clock = 1'b0;
    logic          reset;
    logic          load;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic [AW-2:0] word_count;
    logic          frame_err;
    logic          overflow;

    always #5 clock = ~clock;

    imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .word_count (word_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  m_part[$];
    int          m_n;
    logic        m_frame_err;

    int          n_vec    = 0;
    int          n_mis    = 0;
    int          n_writes = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [AW-1:0] last_waddr = '0;
    logic        prev_load = 1'b0;
    logic        prev_we   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_n         = 0;
        m_frame_err = 1'b0;
        m_part.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        wr_t w;
        if (!good) begin
            m_frame_err = 1'b1;
            m_part.delete();
        end else begin
            m_part.push_back(b);
            if (m_part.size() == 4) begin
                if (m_n < WORDS) begin
                    w.addr = AW'(4 * m_n);
                    w.data = {m_part[0], m_part[1], m_part[2], m_part[3]};
                    exp_q.push_back(w);
                end
                m_n++;
                m_part.delete();
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (reset) begin
            prev_load = 1'b0;
            prev_we   = 1'b0;
        end else begin
            check("cpu_hold", 64'(cpu_hold), 64'(prev_load));
            prev_load = load;
            if (imem_we) begin
                check("we_single_cycle", 64'(prev_we), 64'd0);
                n_writes++;
                last_wdata = imem_wdata;
                last_waddr = imem_addr;
                check("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("we_addr", 64'(imem_addr), 64'(mon_e.addr));
                    check("we_data", 64'(imem_wdata), 64'(mon_e.data));
                end
            end
            prev_we = imem_we;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        model_byte(b, stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        idle(gap);
    endtask

    task automatic send_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, max_gap)));
    endtask

    task automatic set_load(input logic v);
        load = v;
        idle(4);
        if (v) model_reset();
        else m_part.delete();
    endtask

    task automatic check_state(input string tag);
        idle(6);
        check({tag, "_pending"},    64'(exp_q.size()), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'(min_i(m_n, WORDS - 1)));
        check({tag, "_imem_addr"},  64'(imem_addr), 64'(4 * min_i(m_n, WORDS - 1)));
        check({tag, "_frame_err"},  64'(frame_err), 64'(m_frame_err));
        check({tag, "_overflow"},   64'(overflow), 64'(m_n > WORDS));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},         64'(imem_we), 64'd0);
        check({tag, "_addr"},       64'(imem_addr), 64'd0);
        check({tag, "_wdata"},      64'(imem_wdata), 64'd0);
        check({tag, "_cpu_hold"},   64'(cpu_hold), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_frame_err"},  64'(frame_err), 64'd0);
        check({tag, "_overflow"},   64'(overflow), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w_saved;
        reset = 1'b1;
        load  = 1'b0;
        rx    = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        check_zero("reset");
        tick();
        reset = 1'b0;
        idle(5);

        // Known word.
        set_load(1'b1);
        send_byte(8'h20, 1'b1, 3);
        send_byte(8'h01, 1'b1, 3);
        send_byte(8'h00, 1'b1, 3);
        send_byte(8'h05, 1'b1, 0);
        check_state("known");
        check("known_wdata", 64'(last_wdata), 64'h20010005);
        check("known_waddr", 64'(last_waddr), 64'h000);
        check("known_count", 64'(word_count), 64'd1);
        check("known_addr_after", 64'(imem_addr), 64'h004);

        // Eight bytes back-to-back.
        send_random(8, 0);
        check_state("b2b");
        check("b2b_frame_err", 64'(frame_err), 64'd0);

        // One-cycle glitch, then a full word.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        idle(20);
        check("glitch_no_write", 64'(n_writes), 64'd3);
        send_random(4, 2);
        check_state("glitch");

        // Framing error after a good byte; the following four bytes form the word.
        set_load(1'b0);
        set_load(1'b1);
        send_random(1, 2);
        send_byte(8'($urandom), 1'b0, 8);
        idle(4);
        check("ferr_flag", 64'(frame_err), 64'd1);
        send_random(4, 1);
        check_state("ferr");
        check("ferr_waddr", 64'(last_waddr), 64'h000);

        // Partial word discarded across a load toggle.
        send_random(3, 1);
        set_load(1'b0);
        set_load(1'b1);
        send_random(4, 1);
        check_state("partial");
        check("partial_waddr", 64'(last_waddr), 64'h000);
        check("partial_count", 64'(word_count), 64'd1);

        // Fill memory and overflow by one word.
        set_load(1'b0);
        set_load(1'b1);
        w_saved = n_writes;
        send_random(4 * (WORDS + 1), 2);
        check_state("full");
        check("full_writes", 64'(n_writes - w_saved), 64'd128);
        check("full_last_waddr", 64'(last_waddr), 64'h1FC);
        check("full_overflow", 64'(overflow), 64'd1);
        check("full_count", 64'(word_count), 64'd127);

        // Reset in the middle of a byte.
        w_saved = n_writes;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check_zero("midreset");
        rx = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
        idle(6);
        check("midreset_no_write", 64'(n_writes), 64'(w_saved));
        send_random(4, 1);
        check_state("after_reset");
        check("after_reset_waddr", 64'(last_waddr), 64'h000);

        set_load(1'b0);
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
